// File: rtl/rr_arb_pkg.sv
// Shared sizes and state encoding for the 16-way round-robin decode arbiter.
package rr_arb_pkg;
    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;
endpackage

// File: rtl/dec4to16_en.sv
// Enabled 4-to-16 one-hot decoder, built from a row 2-to-4 stage feeding four column 2-to-4 stages.
module dec2to4_en (
    input  logic       i_en,
    input  logic [1:0] i_sel,
    output logic [3:0] o_dec
);
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dec
            assign o_dec[gi] = i_en && (i_sel == 2'(gi));
        end
    endgenerate
endmodule

module dec4to16_en
    import rr_arb_pkg::*;
(
    input  logic             i_en,
    input  logic [IDX_W-1:0] i_idx,
    output logic [N_REQ-1:0] o_onehot
);
    logic [3:0] w_row;

    dec2to4_en u_row (
        .i_en  (i_en),
        .i_sel (i_idx[3:2]),
        .o_dec (w_row)
    );

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            dec2to4_en u_col (
                .i_en  (w_row[gi]),
                .i_sel (i_idx[1:0]),
                .o_dec (o_onehot[gi*4 +: 4])
            );
        end
    endgenerate
endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter over 16 requesters: registered index, decoded one-hot grant,
// bounded-hold preemption and a dead GAP cycle between consecutive grants.
module rr_decode_arbiter
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic             i_clock,
    input  logic             i_resetn,
    input  logic             i_en,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_gnt_valid,
    output logic             o_gnt_start
);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    // Returns {found, index}; scanning downward lets the smallest offset from ptr win.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] cand;
        logic [IDX_W:0]   res;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    state_t           r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_gnt_idx;
    logic             r_gnt_valid;
    logic             r_gnt_start;
    logic [CNT_W-1:0] r_hold_cnt;

    logic [IDX_W:0]   w_pick;
    logic [N_REQ-1:0] w_req_others;
    logic             w_preempt;
    logic             w_exit;

    assign w_pick = rr_pick(i_req, r_ptr);

    always_comb begin
        w_req_others            = i_req;
        w_req_others[r_gnt_idx] = 1'b0;
    end

    assign w_preempt = (r_hold_cnt == HOLD_LAST) && (|w_req_others);
    assign w_exit    = !i_req[r_gnt_idx] || !i_en || w_preempt;

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_start <= 1'b0;
            r_hold_cnt  <= '0;
        end else begin
            r_gnt_start <= 1'b0;
            case (r_state)
                ST_GRANT: begin
                    if (w_exit) begin
                        r_state     <= ST_GAP;
                        r_gnt_valid <= 1'b0;
                        r_ptr       <= r_gnt_idx + IDX_W'(1);
                    end else if (r_hold_cnt != HOLD_LAST) begin
                        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (i_en && w_pick[IDX_W]) begin
                        r_state     <= ST_GRANT;
                        r_gnt_idx   <= w_pick[IDX_W-1:0];
                        r_gnt_valid <= 1'b1;
                        r_gnt_start <= 1'b1;
                        r_hold_cnt  <= '0;
                    end else begin
                        r_state     <= ST_IDLE;
                        r_gnt_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    dec4to16_en u_dec (
        .i_en     (r_gnt_valid),
        .i_idx    (r_gnt_idx),
        .o_onehot (o_gnt)
    );

    assign o_gnt_idx   = r_gnt_idx;
    assign o_gnt_valid = r_gnt_valid;
    assign o_gnt_start = r_gnt_start;
endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench for rr_decode_arbiter: directed scenarios plus random traffic against a grant-level model.
module tb_rr_decode_arbiter;
    localparam int MAX_HOLD = 8;

    logic        clk = 1'b0;
    logic        i_resetn = 1'b0;
    logic        i_en = 1'b0;
    logic [15:0] i_req = '0;
    logic [15:0] o_gnt;
    logic [3:0]  o_gnt_idx;
    logic        o_gnt_valid;
    logic        o_gnt_start;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: who holds the slot, for how many cycles, and where the next scan starts.
    bit m_active;
    bit m_start;
    int m_idx;
    int m_ptr;
    int m_cycles;
    int order_q[$];

    rr_decode_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .i_clock     (clk),
        .i_resetn    (i_resetn),
        .i_en        (i_en),
        .i_req       (i_req),
        .o_gnt       (o_gnt),
        .o_gnt_idx   (o_gnt_idx),
        .o_gnt_valid (o_gnt_valid),
        .o_gnt_start (o_gnt_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_active = 0;
        m_start  = 0;
        m_idx    = 0;
        m_ptr    = 0;
        m_cycles = 0;
    endfunction

    function automatic void model_step(input bit en, input logic [15:0] req);
        bit found;
        m_start = 0;
        if (m_active) begin
            logic [15:0] others;
            others = req & ~(16'd1 << m_idx);
            if (!req[m_idx] || !en || (m_cycles >= MAX_HOLD && others != 0)) begin
                m_active = 0;
                m_ptr    = (m_idx + 1) % 16;
            end else begin
                m_cycles++;
            end
        end else if (en && req != 0) begin
            found = 0;
            for (int k = 0; k < 16 && !found; k++) begin
                if (req[(m_ptr + k) % 16]) begin
                    found    = 1;
                    m_idx    = (m_ptr + k) % 16;
                    m_active = 1;
                    m_start  = 1;
                    m_cycles = 1;
                end
            end
        end
    endfunction

    task automatic cycle(input bit en, input logic [15:0] req);
        @(negedge clk);
        check("gnt", 32'(o_gnt), m_active ? (32'd1 << m_idx) : 32'd0);
        check("gnt_idx", 32'(o_gnt_idx), 32'(m_idx));
        check("gnt_valid", 32'(o_gnt_valid), 32'(m_active));
        check("gnt_start", 32'(o_gnt_start), 32'(m_start));
        if (o_gnt_start) begin
            order_q.push_back(int'(o_gnt_idx));
            $display("grant idx=%0d t=%0t", o_gnt_idx, $time);
        end
        i_en  = en;
        i_req = req;
        model_step(en, req);
    endtask

    task automatic do_reset();
        i_resetn = 1'b0;
        i_en     = 1'b0;
        i_req    = '0;
        model_reset();
        @(negedge clk);
        check("rst_gnt", 32'(o_gnt), 32'd0);
        check("rst_idx", 32'(o_gnt_idx), 32'd0);
        check("rst_valid_start", 32'({o_gnt_valid, o_gnt_start}), 32'd0);
        i_resetn = 1'b1;
    endtask

    initial begin
        int cnt3, cnt_hit, n_start;
        bit e;
        logic [15:0] r;

        do_reset();

        // Async reset in the middle of a grant to requester 5
        cycle(1, 16'h0020);
        cycle(1, 16'h0020);
        cycle(1, 16'h0020);
        check("pre_rst_gnt5", 32'(o_gnt), 32'h0020);
        #2 i_resetn = 1'b0;
        #1;
        check("async_rst_gnt", 32'(o_gnt), 32'd0);
        check("async_rst_valid", 32'(o_gnt_valid), 32'd0);
        do_reset();
        cycle(1, 16'h0020);
        cycle(1, 16'h0020);
        check("post_rst_gnt", 32'(o_gnt), 32'h0020);
        check("post_rst_start", 32'(o_gnt_start), 32'd1);

        // Round robin between 0 and 15, each releasing after two grant cycles
        do_reset();
        order_q.delete();
        for (int k = 0; k < 16; k++) begin
            r = 16'h8001;
            if (m_active && m_cycles >= 2) r[m_idx] = 1'b0;
            cycle(1, r);
        end
        check("rr_count", 32'(order_q.size() >= 4), 32'd1);
        for (int k = 0; k < 4 && k < order_q.size(); k++)
            check("rr_order", 32'(order_q[k]), (k % 2) ? 32'd15 : 32'd0);

        // Pointer wrap after granting 14
        do_reset();
        cycle(1, 16'h4000);
        cycle(1, 16'h4000);
        cycle(1, 16'h0000);
        cycle(1, 16'h4001);
        cycle(1, 16'h4001);
        check("wrap_idx", 32'(o_gnt_idx), 32'd0);
        check("wrap_gnt", 32'(o_gnt), 32'h0001);

        // Preemption after MAX_HOLD cycles
        do_reset();
        cnt3 = 0;
        cycle(1, 16'h0008);
        cycle(1, 16'h0008);
        if (o_gnt == 16'h0008) cnt3++;
        for (int k = 0; k < 14; k++) begin
            cycle(1, 16'h0208);
            if (o_gnt == 16'h0008) cnt3++;
        end
        check("preempt_hold", 32'(cnt3), 32'(MAX_HOLD));
        check("preempt_next", 32'(o_gnt), 32'h0200);

        // Lone requester is never preempted
        do_reset();
        cnt_hit = 0;
        n_start = 0;
        cycle(1, 16'h0010);
        for (int k = 0; k < 40; k++) begin
            cycle(1, 16'h0010);
            if (o_gnt == 16'h0010) cnt_hit++;
            if (o_gnt_start) n_start++;
        end
        check("nopre_cycles", 32'(cnt_hit), 32'd40);
        check("nopre_starts", 32'(n_start), 32'd1);

        // Enable drop mid-grant, blocked arbitration, then resume from ptr 8
        do_reset();
        cycle(1, 16'h0080);
        cycle(1, 16'h0080);
        cycle(1, 16'h0080);
        cycle(0, 16'h0080);
        cycle(0, 16'hFFFF);
        check("en_gap_gnt", 32'(o_gnt), 32'd0);
        for (int k = 0; k < 3; k++) cycle(0, 16'hFFFF);
        check("en_off_valid", 32'(o_gnt_valid), 32'd0);
        cycle(1, 16'hFFFF);
        cycle(1, 16'hFFFF);
        check("en_resume_idx", 32'(o_gnt_idx), 32'd8);
        check("en_resume_gnt", 32'(o_gnt), 32'h0100);

        // Random traffic against the model
        do_reset();
        r = 16'h0000;
        e = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            case ($urandom_range(0, 15))
                0:       r = 16'($urandom);
                1, 2, 3: r[$urandom_range(0, 15)] = ~r[$urandom_range(0, 15)];
                4, 5:    r[$urandom_range(0, 15)] = 1'b0;
                6:       r = 16'h0000;
                default: ;
            endcase
            if ($urandom_range(0, 29) == 0) e = ~e;
            cycle(e, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
